// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer: drives one float16 MAC PE across a stride-1 valid convolution, streaming output pixels in raster order.
// Defining CONV_SEQ_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT) and a sticky ERROR state.
module conv_pe_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int WEIGHT_LENGTH = 3,
  parameter int WEIGHT_WIDTH = 3,
  parameter int IMG_HEIGHT = 8,
  parameter int IMG_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int WADDR_WIDTH = 4
`ifdef CONV_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic [ADDR_WIDTH-1:0] img_addr,
  input  logic [DATA_WIDTH-1:0] img_data,
  output logic [WADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0] wgt_data,
  output logic [DATA_WIDTH-1:0] pe_floatA,
  output logic [DATA_WIDTH-1:0] pe_floatB,
  output logic pe_conv_en,
  input  logic [DATA_WIDTH-1:0] pe_result,
  input  logic pe_out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0] out_col,
  output logic error
);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int KRW = $clog2(WEIGHT_LENGTH + 1);
  localparam int KCW = $clog2(WEIGHT_WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - WEIGHT_LENGTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - WEIGHT_WIDTH);
  localparam logic [KRW-1:0] KR_LAST = KRW'(WEIGHT_LENGTH - 1);
  localparam logic [KCW-1:0] KC_LAST = KCW'(WEIGHT_WIDTH - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE
`ifdef CONV_SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;
  state_t state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [KRW-1:0] kr;
  logic [KCW-1:0] kc;
  logic tap_last, pix_last, xfer;
  assign tap_last = kr == KR_LAST && kc == KC_LAST;
  assign pix_last = row == ROW_LAST && col == COL_LAST;
  assign xfer = state == S_OUT && out_ready;
  assign pe_floatA = img_data;
  assign pe_floatB = wgt_data;
`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
  logic tmo_hit;
  always_ff @(posedge clk) tmo_cnt <= reset || state != S_WAIT ? '0 : tmo_cnt + 1'b1;
  assign tmo_hit = tmo_cnt == TMO_LAST;
`endif
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = tap_last ? S_WAIT : S_FETCH;
`ifdef CONV_SEQ_TIMEOUT_EN
      S_WAIT:  state_nxt = pe_out_valid ? S_OUT : tmo_hit ? S_ERR : S_WAIT;
      S_ERR:   state_nxt = S_ERR;
`else
      S_WAIT:  state_nxt = pe_out_valid ? S_OUT : S_WAIT;
`endif
      S_OUT:   state_nxt = !out_ready ? S_OUT : pix_last ? S_DONE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
    out_valid = state == S_OUT;
    img_addr = state == S_FETCH ? ADDR_WIDTH'((int'(row) + int'(kr)) * IMG_WIDTH + int'(col) + int'(kc)) : '0;
    wgt_addr = state == S_FETCH ? WADDR_WIDTH'(int'(kr) * WEIGHT_WIDTH + int'(kc)) : '0;
`ifdef CONV_SEQ_TIMEOUT_EN
    error = state == S_ERR;
`else
    error = 1'b0;
`endif
  end
  // Enable lags the address by one cycle to line up with the synchronous buffer read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      kr <= '0;
      kc <= '0;
      pe_conv_en <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      pe_conv_en <= state == S_FETCH;
      if (state == S_IDLE && start) begin
        row <= '0;
        col <= '0;
      end
      if (state == S_FETCH) begin
        kc <= kc == KC_LAST ? '0 : kc + 1'b1;
        if (kc == KC_LAST) kr <= kr == KR_LAST ? '0 : kr + 1'b1;
      end
      if (state == S_WAIT && pe_out_valid) begin
        out_data <= pe_result;
        out_row <= row;
        out_col <= col;
      end
      if (xfer) begin
        col <= col == COL_LAST ? '0 : col + 1'b1;
        if (col == COL_LAST) row <= row + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb_conv_pe_sequencer: randomized bench with buffer and PE models, checked against an integer convolution reference.
module tb_conv_pe_sequencer;
  logic clk = 0, reset = 1, start = 0, out_ready = 1, pe_out_valid = 0, pe_mute = 0;
  logic busy, done, pe_conv_en, out_valid, error;
  logic [5:0] img_addr, prev_img;
  logic [3:0] wgt_addr, prev_wgt;
  logic [15:0] img_data = 0, wgt_data = 0, pe_result = 0, pe_floatA, pe_floatB, out_data, last_out;
  logic [2:0] out_row, out_col;
  logic [21:0] held;
  logic en_d = 0, had_win = 0, hold = 0, pv_d = 0, ov_d = 0;
  int checks = 0, errors = 0;
  int img_val [64];
  int wgt_val [9];
  int acc = 0, n_out = 0, n_done = 0, tap = 0, low = 0, stall = 0;
  int win_r = 0, win_c = 0, exp_r = 0, exp_c = 0;

  conv_pe_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .img_addr(img_addr), .img_data(img_data), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .pe_floatA(pe_floatA), .pe_floatB(pe_floatB), .pe_conv_en(pe_conv_en),
    .pe_result(pe_result), .pe_out_valid(pe_out_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .error(error)
  );

  always #5 clk = ~clk;

  function automatic int h2i(logic [15:0] h);
    int e;
    if (h[14:0] == 15'h0) return 0;
    e = int'(h[14:10]) - 15;
    return e < 0 ? 0 : e > 10 ? int'({1'b1, h[9:0]}) << (e - 10) : int'({1'b1, h[9:0]}) >> (10 - e);
  endfunction

  function automatic logic [15:0] i2h(int n);
    int p = 0;
    if (n <= 0) return 16'h0;
    while ((n >> (p + 1)) != 0) p++;
    return {1'b0, 5'(p + 15), 10'((n << (10 - p)) & 1023)};
  endfunction

  function automatic logic [15:0] ref_pix(int r, int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += img_val[(r + i) * 8 + c + j] * wgt_val[i * 3 + j];
    return i2h(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ctl"}, {busy, done, pe_conv_en, out_valid, error}, 0);
    check({tag, "_addr"}, {img_addr, wgt_addr}, 0);
    check({tag, "_out"}, {out_data, out_row, out_col}, 0);
  endtask

  task automatic fill(input bit ones);
    for (int i = 0; i < 64; i++) img_val[i] = ones ? 1 : int'($urandom_range(7));
    for (int i = 0; i < 9; i++) wgt_val[i] = ones ? 2 : int'($urandom_range(3));
  endtask

  // Synchronous image/weight buffers: data one cycle after address.
  always @(posedge clk) begin
    img_data <= i2h(img_val[img_addr]);
    wgt_data <= i2h(wgt_addr < 9 ? wgt_val[wgt_addr] : 0);
  end

  // PE: accumulates while enabled, restarts on the first tap, strobes the sum two cycles after the last tap.
  always @(posedge clk)
    if (reset) begin
      en_d <= 0;
      acc <= 0;
      pe_out_valid <= 0;
    end else begin
      en_d <= pe_conv_en;
      if (pe_conv_en) acc <= (en_d ? acc : 0) + h2i(pe_floatA) * h2i(pe_floatB);
      pe_out_valid <= en_d && !pe_conv_en && !pe_mute;
      pe_result <= i2h(acc);
    end

  always @(negedge clk) begin
    if (reset) begin
      tap = 0; low = 0; had_win = 0; hold = 0;
      win_r = 0; win_c = 0; exp_r = 0; exp_c = 0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_data, out_row, out_col}, held);
      end
      if (out_valid && !ov_d) check("valid_rise", pv_d, 1);
      hold = out_valid && !out_ready;
      held = {out_data, out_row, out_col};
      if (hold) check("stall_en", pe_conv_en, 0);
      if (out_valid && out_ready) begin
        check("pix_data", out_data, ref_pix(exp_r, exp_c));
        check("pix_pos", {out_row, out_col}, {3'(exp_r), 3'(exp_c)});
        last_out = out_data;
        n_out++;
        exp_r = exp_c == 5 ? exp_r + 1 : exp_r;
        exp_c = exp_c == 5 ? 0 : exp_c + 1;
      end
      if (done) begin
        n_done++;
        check("done_after_last", n_out, 36);
      end
      if (pe_conv_en) begin
        if (tap == 0 && had_win) check("en_gap", low >= 2, 1);
        if (tap == 0 && win_r == 5 && win_c == 5) check("addr_55", prev_img, 45);
        check("img_addr", prev_img, (win_r + tap / 3) * 8 + win_c + tap % 3);
        check("wgt_addr", prev_wgt, tap);
        tap++;
      end else begin
        if (tap != 0) begin
          check("en_len", tap, 9);
          had_win = 1;
          low = 0;
          tap = 0;
          win_r = win_c == 5 ? win_r + 1 : win_r;
          win_c = win_c == 5 ? 0 : win_c + 1;
        end
        low++;
      end
    end
    ov_d = out_valid;
    pv_d = pe_out_valid;
    prev_img = img_addr;
    prev_wgt = wgt_addr;
  end

  // mode 0: ready=1, 1: 5-cycle stall on (2,3), 2: random ready + stray starts, 3: reset mid-window (1,4)
  task automatic run_plane(input int mode);
    bit hit = 0;
    n_out = 0; n_done = 0; stall = 0; tap = 0;
    win_r = 0; win_c = 0; exp_r = 0; exp_c = 0;
    @(posedge clk) #1;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    check("busy_set", busy, 1);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (mode == 3 && win_r == 1 && win_c == 4 && tap == 4) begin
        reset = 1;
        @(posedge clk) #1;
        chk_idle("midrst");
        reset = 0;
        hit = 1;
        break;
      end
      out_ready = mode == 1 ? !(out_valid && out_row == 2 && out_col == 3 && stall < 5) :
                  mode == 2 ? $urandom_range(3) != 0 : 1'b1;
      if (!out_ready && mode == 1) stall++;
      start = mode == 2 && $urandom_range(30) == 0;
      @(posedge clk) #1;
    end
    start = 0;
    out_ready = 1;
    if (mode == 3) begin
      check("midrst_hit", hit, 1);
      return;
    end
    check("done_seen", done, 1);
    @(posedge clk) #1;
    check("busy_clr", busy, 0);
    check("n_out", n_out, 36);
    check("n_done", n_done, 1);
  endtask

  initial begin
    fill(1);
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 0;
    run_plane(0);
    check("ones_pix", last_out, 16'h4C80);
    fill(0);
    run_plane(1);
    check("stall_cycles", stall, 5);
    fill(0);
    run_plane(2);
    fill(0);
    run_plane(3);
    fill(0);
    run_plane(0);
`ifdef CONV_SEQ_TIMEOUT_EN
    pe_mute = 1;
    @(posedge clk) #1;
    start = 1;
    @(posedge clk) #1;
    start = 0;
    for (int i = 0; i < 50 && !pe_conv_en; i++) @(posedge clk) #1;
    for (int i = 0; i < 50 && pe_conv_en; i++) @(posedge clk) #1;
    for (int k = 1; k <= 70; k++) begin
      check("tmo_error", error, k >= 64);
      @(posedge clk) #1;
    end
    check("err_strobes", {busy, out_valid, pe_conv_en, done}, 4'b1000);
    reset = 1;
    @(posedge clk) #1;
    reset = 0;
    check("err_clr", error, 0);
    pe_mute = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
